// File: rtl/hamming_mem_engine_if.sv
// Control and byte-memory bus for the Hamming(16,11) SECDED engine.
// master drives run control and read data; slave is the engine side.
interface hamming_mem_engine_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic [7:0]        corr_cnt;
    logic [7:0]        dbl_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport master (
        output start, mode, mem_rd_data,
        input  busy, done, corr_cnt, dbl_cnt,
        input  mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  start, mode, mem_rd_data,
        output busy, done, corr_cnt, dbl_cnt,
        output mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/hamming_mem_engine.sv
// Hamming(16,11) SECDED encode/decode engine walking byte pairs in memory.
// Define HAMMING_ERR_CNT_EN to build the corrected/double-error counters.
module hamming_mem_engine #(
    parameter int NUM_WORDS = 15,
    parameter int ADDR_W    = 8,
    parameter int ENC_SRC   = 0,
    parameter int ENC_DST   = 30,
    parameter int DEC_SRC   = 30,
    parameter int DEC_DST   = 0
) (
    input logic                 clk,
    input logic                 reset,
    hamming_mem_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       word_q, word_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] src_base, dst_base, offs, addr;
    logic [15:0]       enc_d, enc_p, enc_cw;
    logic [15:0]       fixed, dec_out, result;
    logic [3:0]        syn;
    logic              par, last, wr_en;
    logic [7:0]        wr_data;

    // Data bits in place with parity slots zero, then fill p1..p8 and p0.
    assign enc_d  = {word_q[10:4], 1'b0, word_q[3:1], 1'b0, word_q[0], 3'b000};
    assign enc_p  = {7'b0, ^(enc_d & 16'hFF00), 3'b0, ^(enc_d & 16'hF0F0),
                     1'b0, ^(enc_d & 16'hCCCC), ^(enc_d & 16'hAAAA), 1'b0};
    assign enc_cw = {enc_d[15:1] | enc_p[15:1], ^(enc_d | enc_p)};

    assign syn   = {^(word_q & 16'hFF00), ^(word_q & 16'hF0F0),
                    ^(word_q & 16'hCCCC), ^(word_q & 16'hAAAA)};
    assign par   = ^word_q;
    assign fixed = word_q ^ (16'h0001 << syn);

    always_comb begin
        if (par) begin
            dec_out = {5'b01000, fixed[15:9], fixed[7:5], fixed[3]};
        end else if (syn == 4'd0) begin
            dec_out = {5'b00000, word_q[15:9], word_q[7:5], word_q[3]};
        end else begin
            dec_out = 16'h8000;
        end
    end

    assign result   = mode_q ? dec_out : enc_cw;
    assign src_base = mode_q ? ADDR_W'(DEC_SRC) : ADDR_W'(ENC_SRC);
    assign dst_base = mode_q ? ADDR_W'(DEC_DST) : ADDR_W'(ENC_DST);
    assign offs     = {idx_q[ADDR_W-2:0], 1'b0};
    assign last     = (idx_q == ADDR_W'(NUM_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = done_q;
        addr    = '0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                    mode_d  = bus.mode;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RD_LO: begin
                addr         = src_base + offs;
                word_d[7:0]  = bus.mem_rd_data;
                state_d      = RD_HI;
            end
            RD_HI: begin
                addr         = src_base + offs + ADDR_W'(1);
                word_d[15:8] = bus.mem_rd_data;
                state_d      = WR_LO;
            end
            // Both source bytes are held before any write, so in-place is safe.
            WR_LO: begin
                addr    = dst_base + offs;
                wr_en   = 1'b1;
                wr_data = result[7:0];
                state_d = WR_HI;
            end
            WR_HI: begin
                addr    = dst_base + offs + ADDR_W'(1);
                wr_en   = 1'b1;
                wr_data = result[15:8];
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = RD_LO;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_addr    = addr;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_wr_data = wr_data;

`ifdef HAMMING_ERR_CNT_EN
    logic [7:0] corr_q, corr_d, dbl_q, dbl_d;

    always_comb begin
        corr_d = corr_q;
        dbl_d  = dbl_q;
        if (state_q == IDLE && bus.start) begin
            corr_d = 8'h00;
            dbl_d  = 8'h00;
        end else if (state_q == WR_HI && mode_q) begin
            if (par && corr_q != 8'hFF) begin
                corr_d = corr_q + 8'd1;
            end
            if (!par && syn != 4'd0 && dbl_q != 8'hFF) begin
                dbl_d = dbl_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            corr_q <= 8'h00;
            dbl_q  <= 8'h00;
        end else begin
            corr_q <= corr_d;
            dbl_q  <= dbl_d;
        end
    end

    assign bus.corr_cnt = corr_q;
    assign bus.dbl_cnt  = dbl_q;
`else
    assign bus.corr_cnt = 8'h00;
    assign bus.dbl_cnt  = 8'h00;
`endif
endmodule

// File: tb/tb_hamming_mem_engine.sv
// Scoreboard bench for hamming_mem_engine: byte memory model, write log,
// golden Hamming(16,11) encoder/decoder and per-scenario tasks.
module tb_hamming_mem_engine;
    localparam int N       = 15;
    localparam int ENC_SRC = 0;
    localparam int ENC_DST = 30;
    localparam int DEC_SRC = 30;
    localparam int DEC_DST = 30;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hamming_mem_engine_if #(.ADDR_W(8)) bus ();

    hamming_mem_engine #(
        .NUM_WORDS(N), .ADDR_W(8),
        .ENC_SRC(ENC_SRC), .ENC_DST(ENC_DST),
        .DEC_SRC(DEC_SRC), .DEC_DST(DEC_DST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [7:0] mem [0:255];
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr] <= bus.mem_wr_data;
    end
    assign bus.mem_rd_data = mem[bus.mem_addr];

    logic [15:0] act_mem [0:1023];
    int          act_n = 0;
    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1 && act_n < 1024) begin
            act_mem[act_n] <= {bus.mem_addr, bus.mem_wr_data};
            act_n <= act_n + 1;
        end
    end

    logic [15:0] exp_q [$];
    int rd_p   = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] enc_ref(input logic [10:0] m);
        logic [15:0] c;
        int k;
        logic pb;
        c = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            pb = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if ((pos & p) != 0) pb ^= c[pos];
            c[p] = pb;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [15:0] dec_ref(input logic [15:0] w,
                                            output bit corr, output bit dbl);
        int s;
        int k;
        logic [10:0] d;
        logic [15:0] v;
        s = 0;
        v = w;
        corr = 1'b0;
        dbl = 1'b0;
        d = '0;
        for (int pos = 1; pos < 16; pos++) if (w[pos]) s = s ^ pos;
        if (^w) begin
            v[s] = ~v[s];
            corr = 1'b1;
        end else if (s != 0) begin
            dbl = 1'b1;
            return 16'h8000;
        end
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = v[pos];
                k++;
            end
        end
        return {1'b0, corr, 3'b000, d};
    endfunction

    task automatic load_word(input int a, input logic [15:0] w);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = 8'(a);
        ld_data = w[7:0];
        @(negedge clk);
        ld_addr = 8'(a + 1);
        ld_data = w[15:8];
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_word(input int a, input logic [15:0] w);
        exp_q.push_back({8'(a), w[7:0]});
        exp_q.push_back({8'(a + 1), w[15:8]});
    endtask

    task automatic start_run(input logic m);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode = m;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode = ~m;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.done); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", bus.mem_wr_en); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", bus.mem_addr); end
        checks++; if (bus.mem_wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data got %h want 00", bus.mem_wr_data); end
        checks++; if (bus.corr_cnt !== 8'h00) begin errors++; $display("FAIL rst_corr got %h want 00", bus.corr_cnt); end
        checks++; if (bus.dbl_cnt !== 8'h00) begin errors++; $display("FAIL rst_dbl got %h want 00", bus.dbl_cnt); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_decode_directed();
        logic [15:0] din [4];
        logic [15:0] dout [4];
        logic [15:0] w, r, e;
        bit c, d;
        int nc, nd, ec, ed, cyc;
        din  = '{16'hFFDF, 16'hFDDF, 16'h000F, 16'h000E};
        dout = '{16'h47FF, 16'h8000, 16'h0001, 16'h4001};
        nc = 2;
        nd = 1;
        for (int i = 0; i < N; i++) begin
            if (i < 4) begin
                w = din[i];
                r = dout[i];
            end else begin
                w = enc_ref(11'($urandom_range(0, 2047)));
                r = dec_ref(w, c, d);
                nc += int'(c);
                nd += int'(d);
            end
            load_word(DEC_SRC + 2 * i, w);
            push_word(DEC_DST + 2 * i, r);
        end
        start_run(1'b1);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL dec_start busy/done got %b/%b want 1/0", bus.busy, bus.done); end
        wait_done(cyc);
        checks++; if (cyc != 4 * N + 1) begin errors++; $display("FAIL dec_latency got %0d want %0d", cyc, 4 * N + 1); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dec_busy_end got %b want 0", bus.busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_p >= act_n) begin errors++; $display("FAIL dec_wr missing got none want %h", e); end
            else begin
                if (act_mem[rd_p] !== e) begin errors++; $display("FAIL dec_wr[%0d] got %h want %h", rd_p, act_mem[rd_p], e); end
                rd_p++;
            end
        end
        checks++; if (act_n != rd_p) begin errors++; $display("FAIL dec_extra_wr got %0d want %0d", act_n, rd_p); rd_p = act_n; end
`ifdef HAMMING_ERR_CNT_EN
        ec = nc;
        ed = nd;
`else
        ec = 0;
        ed = 0;
`endif
        checks++; if (bus.corr_cnt !== 8'(ec)) begin errors++; $display("FAIL dec_corr got %0d want %0d", bus.corr_cnt, ec); end
        checks++; if (bus.dbl_cnt !== 8'(ed)) begin errors++; $display("FAIL dec_dbl got %0d want %0d", bus.dbl_cnt, ed); end
    endtask

    task automatic test_encode();
        logic [10:0] msg [3];
        logic [15:0] cw [3];
        logic [10:0] m;
        logic [15:0] e;
        int cyc;
        msg = '{11'h000, 11'h7FF, 11'h001};
        cw  = '{16'h0000, 16'hFFFF, 16'h000F};
        for (int i = 0; i < N; i++) begin
            if (i < 3) begin
                load_word(ENC_SRC + 2 * i, {5'b10101, msg[i]});
                push_word(ENC_DST + 2 * i, cw[i]);
            end else begin
                m = 11'($urandom_range(0, 2047));
                load_word(ENC_SRC + 2 * i, {5'($urandom_range(0, 31)), m});
                push_word(ENC_DST + 2 * i, enc_ref(m));
            end
        end
        start_run(1'b0);
        wait_done(cyc);
        checks++; if (cyc != 4 * N + 1) begin errors++; $display("FAIL enc_latency got %0d want %0d", cyc, 4 * N + 1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_p >= act_n) begin errors++; $display("FAIL enc_wr missing got none want %h", e); end
            else begin
                if (act_mem[rd_p] !== e) begin errors++; $display("FAIL enc_wr[%0d] got %h want %h", rd_p, act_mem[rd_p], e); end
                rd_p++;
            end
        end
        checks++; if (act_n != rd_p) begin errors++; $display("FAIL enc_extra_wr got %0d want %0d", act_n, rd_p); rd_p = act_n; end
        checks++; if (bus.corr_cnt !== 8'h00 || bus.dbl_cnt !== 8'h00) begin errors++; $display("FAIL enc_cnt_clear got %h/%h want 00/00", bus.corr_cnt, bus.dbl_cnt); end
    endtask

    task automatic test_inplace_random();
        logic [15:0] w, r, e;
        logic [15:0] res [N];
        bit c, d;
        int kind, b1, b2, nc, nd, ec, ed, cyc;
        nc = 0;
        nd = 0;
        for (int i = 0; i < N; i++) begin
            w = enc_ref(11'($urandom_range(0, 2047)));
            kind = $urandom_range(0, 3);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            if (kind == 1) w[b1] = ~w[b1];
            if (kind == 2) begin w[b1] = ~w[b1]; w[b2] = ~w[b2]; end
            if (kind == 3) begin w[b1] = ~w[b1]; w[b1] = ~w[b1]; end
            r = dec_ref(w, c, d);
            nc += int'(c);
            nd += int'(d);
            res[i] = r;
            load_word(DEC_SRC + 2 * i, w);
            push_word(DEC_DST + 2 * i, r);
        end
        start_run(1'b1);
        wait_done(cyc);
        checks++; if (cyc != 4 * N + 1) begin errors++; $display("FAIL rnd_latency got %0d want %0d", cyc, 4 * N + 1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_p >= act_n) begin errors++; $display("FAIL rnd_wr missing got none want %h", e); end
            else begin
                if (act_mem[rd_p] !== e) begin errors++; $display("FAIL rnd_wr[%0d] got %h want %h", rd_p, act_mem[rd_p], e); end
                rd_p++;
            end
        end
        checks++; if (act_n != rd_p) begin errors++; $display("FAIL rnd_extra_wr got %0d want %0d", act_n, rd_p); rd_p = act_n; end
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({mem[DEC_DST + 2 * i + 1], mem[DEC_DST + 2 * i]} !== res[i]) begin
                errors++;
                $display("FAIL rnd_mem[%0d] got %h want %h", i, {mem[DEC_DST + 2 * i + 1], mem[DEC_DST + 2 * i]}, res[i]);
            end
        end
`ifdef HAMMING_ERR_CNT_EN
        ec = nc;
        ed = nd;
`else
        ec = 0;
        ed = 0;
`endif
        checks++; if (bus.corr_cnt !== 8'(ec)) begin errors++; $display("FAIL rnd_corr got %0d want %0d", bus.corr_cnt, ec); end
        checks++; if (bus.dbl_cnt !== 8'(ed)) begin errors++; $display("FAIL rnd_dbl got %0d want %0d", bus.dbl_cnt, ed); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] m;
        logic [15:0] cw [N];
        logic [15:0] e;
        int cyc;
        for (int i = 0; i < N; i++) begin
            m = 11'($urandom_range(0, 2047));
            cw[i] = enc_ref(m);
            load_word(ENC_SRC + 2 * i, {5'b00000, m});
            push_word(ENC_DST + 2 * i, cw[i]);
        end
        start_run(1'b0);
        fork
            begin
                repeat (3) @(negedge clk);
                bus.start = 1'b1;
                bus.mode = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                bus.mode = 1'b0;
            end
        join_none
        wait_done(cyc);
        checks++; if (cyc != 4 * N + 1) begin errors++; $display("FAIL dbl_start_latency got %0d want %0d", cyc, 4 * N + 1); end
        for (int i = 0; i < N; i++) push_word(ENC_DST + 2 * i, cw[i]);
        start_run(1'b0);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart done/busy got %b/%b want 0/1", bus.done, bus.busy); end
        wait_done(cyc);
        checks++; if (cyc != 4 * N + 1) begin errors++; $display("FAIL b2b_latency got %0d want %0d", cyc, 4 * N + 1); end
        repeat (10) @(negedge clk);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_sticky done/busy got %b/%b want 1/0", bus.done, bus.busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_p >= act_n) begin errors++; $display("FAIL b2b_wr missing got none want %h", e); end
            else begin
                if (act_mem[rd_p] !== e) begin errors++; $display("FAIL b2b_wr[%0d] got %h want %h", rd_p, act_mem[rd_p], e); end
                rd_p++;
            end
        end
        checks++; if (act_n != rd_p) begin errors++; $display("FAIL b2b_extra_wr got %0d want %0d", act_n, rd_p); rd_p = act_n; end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] w, e;
        bit c, d;
        for (int i = 0; i < N; i++) begin
            w = (i == 3) ? 16'h008F : enc_ref(11'($urandom_range(0, 2047)));
            load_word(DEC_SRC + 2 * i, w);
            push_word(DEC_DST + 2 * i, dec_ref(w, c, d));
        end
        start_run(1'b1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 8'(DEC_DST + 6)) begin errors++; $display("FAIL mid_wr_lo en/addr got %b/%h want 1/%h", bus.mem_wr_en, bus.mem_addr, 8'(DEC_DST + 6)); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst busy/done got %b/%b want 0/0", bus.busy, bus.done); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en got %b want 0", bus.mem_wr_en); end
        checks++; if (bus.corr_cnt !== 8'h00 || bus.dbl_cnt !== 8'h00) begin errors++; $display("FAIL mid_rst_cnt got %h/%h want 00/00", bus.corr_cnt, bus.dbl_cnt); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        for (int j = 0; j < 7; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_p >= act_n) begin errors++; $display("FAIL mid_wr missing got none want %h", e); end
            else begin
                if (act_mem[rd_p] !== e) begin errors++; $display("FAIL mid_wr[%0d] got %h want %h", rd_p, act_mem[rd_p], e); end
                rd_p++;
            end
        end
        exp_q.delete();
        checks++; if (act_n != rd_p) begin errors++; $display("FAIL mid_post_rst_wr got %0d want %0d", act_n, rd_p); rd_p = act_n; end
        checks++; if (mem[DEC_DST + 6] !== 8'h8F || mem[DEC_DST + 7] !== 8'h00) begin errors++; $display("FAIL mid_word3_mem got %h%h want 008F", mem[DEC_DST + 7], mem[DEC_DST + 6]); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_idle busy/done got %b/%b want 0/0", bus.busy, bus.done); end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        ld_en = 1'b0;
        ld_addr = 8'h00;
        ld_data = 8'h00;
        test_reset();
        test_decode_directed();
        test_encode();
        test_inplace_random();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
